// File: rtl/led_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_pkg
// Brief    : Shared types and constants for the 8-digit LED scan controller.
// Revision : 1.0 - initial release
// ============================================================================
package led_scan_pkg;

   // Scan FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   // All segments off (active-low bus)
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Decoder enables packed as {E3,E2,E1}
   localparam logic [2:0] ENA_ON  = 3'b100;
   localparam logic [2:0] ENA_OFF = 3'b011;

endpackage
`default_nettype wire

// File: rtl/led_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_ctrl_if
// Brief    : Host load/enable bus plus decoder/segment outputs of the scan
//            controller. master = host side, slave = controller side.
// Revision : 1.0 - initial release
// ============================================================================
interface led_scan_ctrl_if;
   logic        en;
   logic        load;
   logic [31:0] din;
   logic [7:0]  dp_in;
   logic [2:0]  A;
   logic        E3;
   logic        E2;
   logic        E1;
   logic [6:0]  seg;
   logic        dp;
   logic        frame_start;
   logic        pending;

   modport master (
      output en, load, din, dp_in,
      input  A, E3, E2, E1, seg, dp, frame_start, pending
   );

   modport slave (
      input  en, load, din, dp_in,
      output A, E3, E2, E1, seg, dp, frame_start, pending
   );
endinterface
`default_nettype wire

// File: rtl/led_scan_ctrl_hex_to_seg7.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg7
// Brief    : 4-bit hex value to active-low {g,f,e,d,c,b,a} segment pattern.
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_seg7
   import led_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg7
);

   // Full 0-F glyph table, active-low
   always_comb begin
      seg7 = SEG_BLANK;
      case (nibble)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         4'hF: seg7 = 7'h0E;
         default: seg7 = SEG_BLANK;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_scan_ctrl
// Brief    : 8-digit time-multiplexed seven-segment scan controller driving a
//            3-to-8 active-low decoder. Double-buffered display data is
//            committed only at frame wrap; each slot starts with a blanking
//            window to suppress ghosting.
// Revision : 1.0 - initial release
// ============================================================================
module led_scan_ctrl
   import led_scan_pkg::*;
#(
   parameter int DIV   = 50000,
   parameter int BLANK = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   led_scan_ctrl_if.slave    bus
);

   localparam int            CW        = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    a_q, a_d;
   logic [39:0]   shadow_q, shadow_d;   // {dp[7:0], digits[31:0]}
   logic [39:0]   active_q, active_d;
   logic          pending_q, pending_d;
   logic [2:0]    ena_q, ena_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          fs_q, fs_d;

   logic          wrap;
   logic [3:0]    digit_nib;
   logic [7:0]    dp_vec;
   logic [6:0]    glyph;

   // Sequencing: slot counter, digit index and state, with en=0 forcing IDLE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      wrap    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.en) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               a_d     = 3'd0;
               wrap    = 1'b1;   // starting a scan is a frame boundary
            end
         end
         ST_BLANK, ST_SHOW: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               a_d     = a_q + 3'd1;
               state_d = ST_BLANK;
               wrap    = (a_q == 3'd7);
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CNT_BLANK) begin
                  state_d = ST_SHOW;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            a_d     = 3'd0;
         end
      endcase
      if (!bus.en) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         a_d     = 3'd0;
         wrap    = 1'b0;
      end
   end

   // Double buffer: commit shadow at wrap; a load coinciding with wrap goes straight to active
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (wrap) begin
         if (bus.load) begin
            shadow_d  = {bus.dp_in, bus.din};
            active_d  = {bus.dp_in, bus.din};
            pending_d = 1'b0;
         end else if (pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
         end
      end else if (bus.load) begin
         shadow_d  = {bus.dp_in, bus.din};
         pending_d = 1'b1;
      end
   end

   // Single glyph encoder on the digit mux, addressed by the next digit index
   always_comb begin
      digit_nib = active_d[{a_d, 2'b00} +: 4];
      dp_vec    = active_d[39:32];
   end

   hex_to_seg7 u_hex_to_seg7 (
      .nibble (digit_nib),
      .seg7   (glyph)
   );

   // Output values derived from the next state so address and data move together
   always_comb begin
      ena_d = ENA_OFF;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      fs_d  = wrap;
      if (state_d == ST_SHOW) begin
         ena_d = ENA_ON;
         seg_d = glyph;
         dp_d  = ~dp_vec[a_d];
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         a_q       <= 3'd0;
         shadow_q  <= '0;
         active_q  <= '0;
         pending_q <= 1'b0;
         ena_q     <= ENA_OFF;
         seg_q     <= SEG_BLANK;
         dp_q      <= 1'b1;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         a_q       <= a_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         ena_q     <= ena_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         fs_q      <= fs_d;
      end
   end

   assign bus.A           = a_q;
   assign bus.E3          = ena_q[2];
   assign bus.E2          = ena_q[1];
   assign bus.E1          = ena_q[0];
   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.frame_start = fs_q;
   assign bus.pending     = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_scan_ctrl
// Brief    : Directed self-checking bench for led_scan_ctrl (DIV=8, BLANK=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_scan_ctrl;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   led_scan_ctrl_if bus ();

   led_scan_ctrl #(.DIV(8), .BLANK(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference glyphs, active-low {g,f,e,d,c,b,a}
   logic [6:0] hexv [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_off(input string tag);
      chk({tag, "_ena"}, {29'd0, bus.E3, bus.E2, bus.E1}, 32'h3);
      chk({tag, "_seg"}, {25'd0, bus.seg}, 32'h7F);
      chk({tag, "_dp"},  {31'd0, bus.dp}, 32'h1);
      chk({tag, "_a"},   {29'd0, bus.A}, 32'h0);
   endtask

   initial begin
      errors = 0;
      checks = 0;

      // Reset dominates en and load
      rst_n     = 1'b0;
      bus.en    = 1'b1;
      bus.load  = 1'b1;
      bus.din   = 32'hFFFF_FFFF;
      bus.dp_in = 8'hFF;
      step(3);
      chk_off("rst");
      chk("rst_pend", {31'd0, bus.pending}, 32'h0);
      chk("rst_fs", {31'd0, bus.frame_start}, 32'h0);

      // Release: first frame shows zeros
      rst_n    = 1'b1;
      bus.load = 1'b0;
      step(1);
      chk("rel_fs", {31'd0, bus.frame_start}, 32'h1);
      step(2);
      chk("rel_seg", {25'd0, bus.seg}, 32'h40);
      chk("rel_dp", {31'd0, bus.dp}, 32'h1);
      chk("rel_pend", {31'd0, bus.pending}, 32'h0);

      // Back to IDLE, then load while idle
      bus.en = 1'b0;
      step(1);
      chk_off("idle");
      bus.load  = 1'b1;
      bus.din   = 32'h7654_3210;
      bus.dp_in = 8'h01;
      step(1);
      bus.load = 1'b0;
      chk("idle_pend", {31'd0, bus.pending}, 32'h1);

      // Scan one full frame plus the next frame entry
      bus.en = 1'b1;
      step(1);
      chk("scan_pend", {31'd0, bus.pending}, 32'h0);
      for (int c = 0; c <= 64; c++) begin
         chk("scan_a", {29'd0, bus.A}, 32'((c % 64) / 8));
         chk("scan_ena", {29'd0, bus.E3, bus.E2, bus.E1}, ((c % 8) < 2) ? 32'h3 : 32'h4);
         chk("scan_fs", {31'd0, bus.frame_start}, (c % 64 == 0) ? 32'h1 : 32'h0);
         if ((c % 8) >= 2) begin
            chk("scan_seg", {25'd0, bus.seg}, {25'd0, hexv[(c / 8) % 8]});
            chk("scan_dp", {31'd0, bus.dp}, ((c / 8) == 0) ? 32'h0 : 32'h1);
         end
         if (c < 64) step(1);
      end

      // Mid-frame load during SHOW of digit 3 (c=90)
      step(26);
      chk("mid_a3", {29'd0, bus.A}, 32'h3);
      bus.load  = 1'b1;
      bus.din   = 32'hFFFF_FFFF;
      bus.dp_in = 8'h00;
      step(1);
      bus.load = 1'b0;
      chk("mid_pend", {31'd0, bus.pending}, 32'h1);
      chk("mid_seg3", {25'd0, bus.seg}, 32'h30);
      step(31);
      chk("mid_a7", {29'd0, bus.A}, 32'h7);
      chk("mid_seg7", {25'd0, bus.seg}, 32'h78);
      chk("mid_pend7", {31'd0, bus.pending}, 32'h1);
      step(6);
      chk("wrap_fs", {31'd0, bus.frame_start}, 32'h1);
      chk("wrap_a", {29'd0, bus.A}, 32'h0);
      chk("wrap_pend", {31'd0, bus.pending}, 32'h0);
      step(2);
      chk("wrap_seg", {25'd0, bus.seg}, 32'h0E);
      chk("wrap_dp", {31'd0, bus.dp}, 32'h1);

      // Load coincident with the wrap edge (c=191 -> 192)
      step(61);
      chk("co_a7", {29'd0, bus.A}, 32'h7);
      chk("co_pend0", {31'd0, bus.pending}, 32'h0);
      bus.load  = 1'b1;
      bus.din   = 32'h8888_8888;
      bus.dp_in = 8'hFF;
      step(1);
      bus.load = 1'b0;
      chk("co_fs", {31'd0, bus.frame_start}, 32'h1);
      chk("co_pend1", {31'd0, bus.pending}, 32'h0);
      step(2);
      chk("co_seg", {25'd0, bus.seg}, 32'h00);
      chk("co_dp", {31'd0, bus.dp}, 32'h0);
      chk("co_pend2", {31'd0, bus.pending}, 32'h0);

      // Disable during SHOW of digit 5 (c=234)
      step(40);
      chk("dis_a5", {29'd0, bus.A}, 32'h5);
      chk("dis_ena5", {29'd0, bus.E3, bus.E2, bus.E1}, 32'h4);
      bus.en = 1'b0;
      step(1);
      chk_off("dis");
      step(1);
      chk_off("dis2");
      bus.en = 1'b1;
      step(1);
      chk("re_fs", {31'd0, bus.frame_start}, 32'h1);
      chk("re_a", {29'd0, bus.A}, 32'h0);
      chk("re_ena", {29'd0, bus.E3, bus.E2, bus.E1}, 32'h3);
      step(2);
      chk("re_seg", {25'd0, bus.seg}, 32'h00);

      // Reset mid-SHOW with data pending
      bus.load  = 1'b1;
      bus.din   = 32'h1234_5678;
      bus.dp_in = 8'h00;
      step(1);
      bus.load = 1'b0;
      chk("rs_pend1", {31'd0, bus.pending}, 32'h1);
      rst_n = 1'b0;
      step(1);
      chk_off("rs");
      chk("rs_fs", {31'd0, bus.frame_start}, 32'h0);
      chk("rs_pend0", {31'd0, bus.pending}, 32'h0);
      rst_n = 1'b1;
      step(3);
      chk("rs_seg", {25'd0, bus.seg}, 32'h40);
      chk("rs_pend2", {31'd0, bus.pending}, 32'h0);
      step(64);
      chk("rs_seg_next", {25'd0, bus.seg}, 32'h40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
